// File: rtl/hms_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module : hms_countdown_timer
// hh:mm:ss BCD countdown timer with preset memory, auto-reload and alert.
// Rev    : 1.0
// ============================================================================
module hms_countdown_timer #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int MAX_HOUR        = 23,
  parameter int ALERT_TIMEOUT_S = 60,
  parameter int AUTO_RELOAD     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        field_sel,
  input  logic        inc,
  input  logic        dec,
  input  logic        clear,
  input  logic        ack,
  output logic [23:0] time_value,
  output logic [1:0]  state,
  output logic [1:0]  cursor_pos,
  output logic        alert,
  output logic        expired_p
);

  localparam int TICK_W = $clog2(CLK_FREQ);
  localparam int ASEC_W = (ALERT_TIMEOUT_S > 2) ? $clog2(ALERT_TIMEOUT_S) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ - 1);
  localparam logic [ASEC_W-1:0] ASEC_LAST =
    ASEC_W'((ALERT_TIMEOUT_S > 0) ? (ALERT_TIMEOUT_S - 1) : 0);
  localparam logic [7:0] HOUR_TOP = 8'(((MAX_HOUR / 10) * 16) + (MAX_HOUR % 10));

  typedef enum logic [1:0] {
    ST_SET     = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t              cur_state, nxt_state;
  logic [23:0]         value, value_nxt;
  logic [23:0]         preset, preset_nxt;
  logic [1:0]          cursor, cursor_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_nxt;
  logic                pend, pend_nxt;
  logic                alert_nxt, expired_p_nxt;
  logic [TICK_W-1:0]   alert_div, alert_div_nxt;
  logic [ASEC_W-1:0]   alert_sec, alert_sec_nxt;
  logic [23:0]         value_dec;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)              return 8'h00;
    else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    else                       return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00)            return top;
    else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    else                       return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // One-second decrement with borrow; never applied to an all-zero value.
  assign value_dec[7:0]   = bcd_dec(value[7:0], 8'h59);
  assign value_dec[15:8]  = (value[7:0] == 8'h00) ? bcd_dec(value[15:8], 8'h59)
                                                  : value[15:8];
  assign value_dec[23:16] = (value[15:0] == 16'h0000) ? bcd_dec(value[23:16], HOUR_TOP)
                                                      : value[23:16];

  assign time_value = value;
  assign state      = cur_state;
  assign cursor_pos = cursor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_SET;
      value     <= '0;
      preset    <= '0;
      cursor    <= '0;
      tick_cnt  <= '0;
      pend      <= 1'b0;
      alert     <= 1'b0;
      expired_p <= 1'b0;
      alert_div <= '0;
      alert_sec <= '0;
    end else begin
      cur_state <= nxt_state;
      value     <= value_nxt;
      preset    <= preset_nxt;
      cursor    <= cursor_nxt;
      tick_cnt  <= tick_cnt_nxt;
      pend      <= pend_nxt;
      alert     <= alert_nxt;
      expired_p <= expired_p_nxt;
      alert_div <= alert_div_nxt;
      alert_sec <= alert_sec_nxt;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    value_nxt     = value;
    preset_nxt    = preset;
    cursor_nxt    = cursor;
    tick_cnt_nxt  = tick_cnt;
    pend_nxt      = pend;
    alert_nxt     = alert;
    expired_p_nxt = 1'b0;
    alert_div_nxt = alert_div;
    alert_sec_nxt = alert_sec;

    if (alert) begin
      if (alert_div == TICK_LAST) begin
        alert_div_nxt = '0;
        if (ALERT_TIMEOUT_S != 0) begin
          if (alert_sec == ASEC_LAST) begin
            alert_nxt     = 1'b0;
            alert_sec_nxt = '0;
          end else begin
            alert_sec_nxt = alert_sec + 1'b1;
          end
        end
      end else begin
        alert_div_nxt = alert_div + 1'b1;
      end
    end

    if (clear) begin
      nxt_state     = ST_SET;
      value_nxt     = '0;
      cursor_nxt    = '0;
      tick_cnt_nxt  = '0;
      pend_nxt      = 1'b0;
      alert_nxt     = 1'b0;
      alert_div_nxt = '0;
      alert_sec_nxt = '0;
    end else begin
      if (ack) begin
        alert_nxt     = 1'b0;
        alert_div_nxt = '0;
        alert_sec_nxt = '0;
        if (cur_state == ST_EXPIRED) begin
          nxt_state = ST_SET;
          value_nxt = preset;
        end
      end

      case (cur_state)
        ST_SET: begin
          if (start_stop) begin
            if (value != 24'h000000) begin
              nxt_state    = ST_RUN;
              preset_nxt   = value;
              tick_cnt_nxt = '0;
              cursor_nxt   = '0;
            end
          end else if (field_sel) begin
            cursor_nxt = (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
          end else if (inc || dec) begin
            case (cursor)
              2'd1:    value_nxt[15:8]  = inc ? bcd_inc(value[15:8], 8'h59)
                                              : bcd_dec(value[15:8], 8'h59);
              2'd2:    value_nxt[23:16] = inc ? bcd_inc(value[23:16], HOUR_TOP)
                                              : bcd_dec(value[23:16], HOUR_TOP);
              default: value_nxt[7:0]   = inc ? bcd_inc(value[7:0], 8'h59)
                                              : bcd_dec(value[7:0], 8'h59);
            endcase
          end
        end

        ST_RUN: begin
          // Expiry lands one cycle after the tick that reached zero.
          if (pend) begin
            pend_nxt      = 1'b0;
            expired_p_nxt = 1'b1;
            alert_nxt     = 1'b1;
            alert_div_nxt = '0;
            alert_sec_nxt = '0;
            if (AUTO_RELOAD != 0) value_nxt = preset;
            else                  nxt_state = ST_EXPIRED;
          end
          if (start_stop) begin
            if (AUTO_RELOAD != 0 || !pend) nxt_state = ST_PAUSE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt = '0;
            value_nxt    = value_dec;
            if (value == 24'h000001) pend_nxt = 1'b1;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end

        ST_PAUSE: begin
          if (start_stop) nxt_state = ST_RUN;
        end

        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hms_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module : tb_hms_countdown_timer
// Directed self-checking bench for hms_countdown_timer (CLK_FREQ = 10).
// Rev    : 1.0
// ============================================================================
module tb_hms_countdown_timer;

  localparam int CLK_FREQ = 10;
  localparam logic [5:0] B_CLR = 6'b100000;
  localparam logic [5:0] B_SS  = 6'b010000;
  localparam logic [5:0] B_FS  = 6'b001000;
  localparam logic [5:0] B_INC = 6'b000100;
  localparam logic [5:0] B_DEC = 6'b000010;
  localparam logic [5:0] B_ACK = 6'b000001;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  btn   = '0;
  logic        clear, start_stop, field_sel, inc, dec, ack;
  logic [23:0] a_time, b_time;
  logic [1:0]  a_state, b_state, a_cursor, b_cursor;
  logic        a_alert, b_alert, a_exp, b_exp;
  int          n_cmp = 0;
  int          n_err = 0;

  assign {clear, start_stop, field_sel, inc, dec, ack} = btn;

  always #5 clk = ~clk;

  hms_countdown_timer #(
    .CLK_FREQ(CLK_FREQ), .MAX_HOUR(23), .ALERT_TIMEOUT_S(3), .AUTO_RELOAD(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start_stop(start_stop), .field_sel(field_sel),
    .inc(inc), .dec(dec), .clear(clear), .ack(ack),
    .time_value(a_time), .state(a_state), .cursor_pos(a_cursor),
    .alert(a_alert), .expired_p(a_exp)
  );

  hms_countdown_timer #(
    .CLK_FREQ(CLK_FREQ), .MAX_HOUR(23), .ALERT_TIMEOUT_S(2), .AUTO_RELOAD(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start_stop(start_stop), .field_sel(field_sel),
    .inc(inc), .dec(dec), .clear(clear), .ack(ack),
    .time_value(b_time), .state(b_state), .cursor_pos(b_cursor),
    .alert(b_alert), .expired_p(b_exp)
  );

  // Tasks start and end on a falling edge; a press spans exactly one rising edge.
  task automatic press(input logic [5:0] b);
    btn = b;
    @(negedge clk);
    btn = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_time !== 24'h0)   begin n_err++; $display("FAIL reset_time: got %h want %h", a_time, 24'h0); end
    n_cmp++; if (a_state !== 2'd0)   begin n_err++; $display("FAIL reset_state: got %0d want 0", a_state); end
    n_cmp++; if (a_cursor !== 2'd0)  begin n_err++; $display("FAIL reset_cursor: got %0d want 0", a_cursor); end
    n_cmp++; if (a_alert !== 1'b0)   begin n_err++; $display("FAIL reset_alert: got %b want 0", a_alert); end
    n_cmp++; if (a_exp !== 1'b0)     begin n_err++; $display("FAIL reset_expired_p: got %b want 0", a_exp); end
    n_cmp++; if (b_state !== 2'd0)   begin n_err++; $display("FAIL reset_state_b: got %0d want 0", b_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set_edit;
    press(B_FS);
    repeat (61) press(B_INC);
    n_cmp++; if (a_time !== 24'h000100) begin n_err++; $display("FAIL set_min_wrap: got %h want 000100", a_time); end
    n_cmp++; if (a_cursor !== 2'd1)     begin n_err++; $display("FAIL set_cursor_min: got %0d want 1", a_cursor); end
    press(B_FS);
    press(B_DEC);
    n_cmp++; if (a_time !== 24'h230100) begin n_err++; $display("FAIL set_hour_dec_wrap: got %h want 230100", a_time); end
    n_cmp++; if (a_cursor !== 2'd2)     begin n_err++; $display("FAIL set_cursor_hour: got %0d want 2", a_cursor); end
    press(B_FS);
    n_cmp++; if (a_cursor !== 2'd0)     begin n_err++; $display("FAIL set_cursor_wrap: got %0d want 0", a_cursor); end
    press(B_DEC);
    n_cmp++; if (a_time !== 24'h230159) begin n_err++; $display("FAIL set_sec_dec_wrap: got %h want 230159", a_time); end
    press(B_INC);
    n_cmp++; if (a_time !== 24'h230100) begin n_err++; $display("FAIL set_sec_inc_wrap: got %h want 230100", a_time); end
    press(B_CLR);
    n_cmp++; if (a_time !== 24'h0)      begin n_err++; $display("FAIL set_clear: got %h want 000000", a_time); end
  endtask

  task automatic test_expire_ack;
    repeat (3) press(B_INC);
    n_cmp++; if (a_time !== 24'h000003) begin n_err++; $display("FAIL exp_preset: got %h want 000003", a_time); end
    press(B_SS);
    n_cmp++; if (a_state !== 2'd1)      begin n_err++; $display("FAIL exp_run: got %0d want 1", a_state); end
    cycles(9);
    n_cmp++; if (a_time !== 24'h000003) begin n_err++; $display("FAIL exp_pre_tick: got %h want 000003", a_time); end
    cycles(1);
    n_cmp++; if (a_time !== 24'h000002) begin n_err++; $display("FAIL exp_first_tick: got %h want 000002", a_time); end
    cycles(20);
    n_cmp++; if (a_time !== 24'h0 || a_exp !== 1'b0 || a_state !== 2'd1)
      begin n_err++; $display("FAIL exp_zero_tick: time %h exp %b state %0d want 000000 0 1", a_time, a_exp, a_state); end
    cycles(1);
    n_cmp++; if (a_exp !== 1'b1 || a_alert !== 1'b1 || a_state !== 2'd3)
      begin n_err++; $display("FAIL exp_pulse: exp %b alert %b state %0d want 1 1 3", a_exp, a_alert, a_state); end
    cycles(1);
    n_cmp++; if (a_exp !== 1'b0 || a_alert !== 1'b1)
      begin n_err++; $display("FAIL exp_pulse_width: exp %b alert %b want 0 1", a_exp, a_alert); end
    press(B_INC);
    press(B_SS);
    n_cmp++; if (a_time !== 24'h0 || a_state !== 2'd3)
      begin n_err++; $display("FAIL exp_ignore_btn: time %h state %0d want 000000 3", a_time, a_state); end
    press(B_ACK);
    n_cmp++; if (a_state !== 2'd0 || a_time !== 24'h000003 || a_alert !== 1'b0)
      begin n_err++; $display("FAIL exp_ack: state %0d time %h alert %b want 0 000003 0", a_state, a_time, a_alert); end
  endtask

  task automatic test_alert_timeout;
    press(B_SS);
    cycles(31);
    n_cmp++; if (a_state !== 2'd3 || a_alert !== 1'b1)
      begin n_err++; $display("FAIL to_expired: state %0d alert %b want 3 1", a_state, a_alert); end
    cycles(29);
    n_cmp++; if (a_alert !== 1'b1) begin n_err++; $display("FAIL to_alert_held: got %b want 1", a_alert); end
    cycles(1);
    n_cmp++; if (a_alert !== 1'b0 || a_state !== 2'd3)
      begin n_err++; $display("FAIL to_alert_drop: alert %b state %0d want 0 3", a_alert, a_state); end
    press(B_ACK);
    n_cmp++; if (a_state !== 2'd0 || a_time !== 24'h000003)
      begin n_err++; $display("FAIL to_ack: state %0d time %h want 0 000003", a_state, a_time); end
  endtask

  task automatic test_borrow;
    press(B_CLR);
    press(B_FS);
    press(B_INC);
    press(B_SS);
    n_cmp++; if (a_cursor !== 2'd0 || a_state !== 2'd1)
      begin n_err++; $display("FAIL br_cursor_run: cursor %0d state %0d want 0 1", a_cursor, a_state); end
    cycles(10);
    n_cmp++; if (a_time !== 24'h000059) begin n_err++; $display("FAIL br_min: got %h want 000059", a_time); end
    press(B_CLR);
    press(B_FS);
    press(B_FS);
    press(B_INC);
    press(B_SS);
    cycles(10);
    n_cmp++; if (a_time !== 24'h005959) begin n_err++; $display("FAIL br_hour: got %h want 005959", a_time); end
    press(B_CLR);
  endtask

  task automatic test_pause;
    repeat (5) press(B_INC);
    press(B_SS);
    cycles(6);
    press(B_SS);
    n_cmp++; if (a_state !== 2'd2 || a_time !== 24'h000005)
      begin n_err++; $display("FAIL pa_enter: state %0d time %h want 2 000005", a_state, a_time); end
    press(B_INC);
    cycles(50);
    n_cmp++; if (a_state !== 2'd2 || a_time !== 24'h000005)
      begin n_err++; $display("FAIL pa_frozen: state %0d time %h want 2 000005", a_state, a_time); end
    press(B_SS);
    n_cmp++; if (a_state !== 2'd1) begin n_err++; $display("FAIL pa_resume: got %0d want 1", a_state); end
    cycles(3);
    n_cmp++; if (a_time !== 24'h000005) begin n_err++; $display("FAIL pa_pre_tick: got %h want 000005", a_time); end
    cycles(1);
    n_cmp++; if (a_time !== 24'h000004) begin n_err++; $display("FAIL pa_tick: got %h want 000004", a_time); end
    press(B_CLR);
  endtask

  task automatic test_auto_reload;
    repeat (2) press(B_INC);
    n_cmp++; if (b_time !== 24'h000002) begin n_err++; $display("FAIL ar_preset: got %h want 000002", b_time); end
    press(B_SS);
    cycles(20);
    n_cmp++; if (b_time !== 24'h0 || b_exp !== 1'b0)
      begin n_err++; $display("FAIL ar_zero: time %h exp %b want 000000 0", b_time, b_exp); end
    cycles(1);
    n_cmp++; if (b_exp !== 1'b1 || b_state !== 2'd1 || b_alert !== 1'b1 || b_time !== 24'h000002)
      begin n_err++; $display("FAIL ar_first: exp %b state %0d alert %b time %h want 1 1 1 000002", b_exp, b_state, b_alert, b_time); end
    cycles(19);
    n_cmp++; if (b_exp !== 1'b0 || b_alert !== 1'b1 || b_time !== 24'h0)
      begin n_err++; $display("FAIL ar_between: exp %b alert %b time %h want 0 1 000000", b_exp, b_alert, b_time); end
    cycles(1);
    n_cmp++; if (b_exp !== 1'b1 || b_alert !== 1'b1 || b_time !== 24'h000002)
      begin n_err++; $display("FAIL ar_second: exp %b alert %b time %h want 1 1 000002", b_exp, b_alert, b_time); end
    cycles(20);
    n_cmp++; if (b_exp !== 1'b1 || b_alert !== 1'b1 || b_state !== 2'd1)
      begin n_err++; $display("FAIL ar_third: exp %b alert %b state %0d want 1 1 1", b_exp, b_alert, b_state); end
    press(B_CLR);
    n_cmp++; if (b_state !== 2'd0 || b_time !== 24'h0 || b_alert !== 1'b0)
      begin n_err++; $display("FAIL ar_clear: state %0d time %h alert %b want 0 000000 0", b_state, b_time, b_alert); end
  endtask

  task automatic test_zero_priority;
    press(B_SS);
    n_cmp++; if (a_state !== 2'd0) begin n_err++; $display("FAIL zp_start_zero: got %0d want 0", a_state); end
    press(B_SS | B_INC);
    n_cmp++; if (a_state !== 2'd0 || a_time !== 24'h0)
      begin n_err++; $display("FAIL zp_ss_over_inc: state %0d time %h want 0 000000", a_state, a_time); end
    repeat (2) press(B_INC);
    press(B_CLR | B_INC);
    n_cmp++; if (a_time !== 24'h0) begin n_err++; $display("FAIL zp_clear_over_inc: got %h want 000000", a_time); end
    press(B_FS | B_INC);
    n_cmp++; if (a_cursor !== 2'd1 || a_time !== 24'h0)
      begin n_err++; $display("FAIL zp_fs_over_inc: cursor %0d time %h want 1 000000", a_cursor, a_time); end
    press(B_CLR);
  endtask

  task automatic test_reset_mid;
    logic saw_exp;
    press(B_INC);
    press(B_SS);
    cycles(10);
    n_cmp++; if (a_time !== 24'h0 || a_state !== 2'd1)
      begin n_err++; $display("FAIL rm_pre: time %h state %0d want 000000 1", a_time, a_state); end
    reset = 1'b1;
    #1;
    n_cmp++; if (a_state !== 2'd0 || a_time !== 24'h0 || a_alert !== 1'b0 || a_exp !== 1'b0)
      begin n_err++; $display("FAIL rm_async: state %0d time %h alert %b exp %b want 0 000000 0 0", a_state, a_time, a_alert, a_exp); end
    saw_exp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_exp !== 1'b0) saw_exp = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (a_exp !== 1'b0) saw_exp = 1'b1;
    n_cmp++; if (saw_exp !== 1'b0) begin n_err++; $display("FAIL rm_no_expiry: got %b want 0", saw_exp); end
    press(B_SS);
    n_cmp++; if (a_state !== 2'd0) begin n_err++; $display("FAIL rm_preset_gone: got %0d want 0", a_state); end
  endtask

  initial begin
    test_reset();
    test_set_edit();
    test_expire_ack();
    test_alert_timeout();
    test_borrow();
    test_pause();
    test_auto_reload();
    test_zero_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
